friction_handler: RTL

Per-frame friction and motion-settle stage directly upstream of the ball position/collision handler. Each frame, it consumes the clamped ball speeds that stage produces and decays each speed component toward zero at a fixed frame cadence. It returns the decayed speeds as the `*speed*_prev` values used for the next position update. It also reports per-ball friction state and emits the single-frame `done_fric_all` pulse once every ball has come to rest after a shot.

---
 rtl/pool_pkg.sv | 20 ++
 rtl/ball_friction.sv | 90 +++++++++
 rtl/friction_handler.sv | 97 +++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared pool-table definitions: speed width, per-ball friction codes and
// the settle FSM state set used by the friction stage.
package pool_pkg;
   localparam int SPEED_W = 11;
   localparam int CNT_W   = 8;

   typedef enum logic [2:0] {
      FRIC_STOPPED  = 3'd0,
      FRIC_ROLLING  = 3'd1,
      FRIC_DECEL    = 3'd2,
      FRIC_POCKETED = 3'd3
   } fric_state_e;

   typedef enum logic [1:0] {
      SET_WAIT_SHOT = 2'd0,
      SET_MOVING    = 2'd1,
      SET_SETTLING  = 2'd2,
      SET_DONE      = 2'd3
   } settle_state_e;
endpackage

// File: rtl/ball_friction.sv
// One ball's friction FSM: passes speeds through while rolling and pulls each
// nonzero component one step toward zero every FRIC_PERIOD moving frames.
module ball_friction
   import pool_pkg::*;
#(
   parameter int SPEED_W     = pool_pkg::SPEED_W,
   parameter int FRIC_PERIOD = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [SPEED_W-1:0] xspeed_i,
   input  logic [SPEED_W-1:0] yspeed_i,
   input  logic               pocketed_i,
   output logic [SPEED_W-1:0] xspeed_o,
   output logic [SPEED_W-1:0] yspeed_o,
   output logic [2:0]         state_o,
   output logic               moving_o,
   output logic               at_rest_o
);
   localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(FRIC_PERIOD - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
   localparam logic [SPEED_W-1:0] ONE          = SPEED_W'(1);
   localparam logic [SPEED_W-1:0] MOST_NEG     = {1'b1, {(SPEED_W-1){1'b0}}};
   localparam logic [SPEED_W-1:0] MOST_NEG_SAT = MOST_NEG + ONE;

   fric_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SPEED_W-1:0] x_q, x_d;
   logic [SPEED_W-1:0] y_q, y_d;

   // The most negative code has no positive twin, so fold it in by one first.
   function automatic logic [SPEED_W-1:0] decay(input logic [SPEED_W-1:0] v);
      logic [SPEED_W-1:0] s;
      s = (v == MOST_NEG) ? MOST_NEG_SAT : v;
      if (s == '0)
         decay = '0;
      else if (s[SPEED_W-1])
         decay = s + ONE;
      else
         decay = s - ONE;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      if (pocketed_i) begin
         state_d = FRIC_POCKETED;
         cnt_d   = '0;
         x_d     = '0;
         y_d     = '0;
      end else if (state_q == FRIC_POCKETED || (xspeed_i == '0 && yspeed_i == '0)) begin
         state_d = FRIC_STOPPED;
         cnt_d   = '0;
         x_d     = '0;
         y_d     = '0;
      end else if (cnt_q != CNT_LAST) begin
         state_d = FRIC_ROLLING;
         cnt_d   = cnt_q + CNT_ONE;
         x_d     = xspeed_i;
         y_d     = yspeed_i;
      end else begin
         state_d = FRIC_DECEL;
         cnt_d   = '0;
         x_d     = decay(xspeed_i);
         y_d     = decay(yspeed_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= FRIC_STOPPED;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign xspeed_o  = x_q;
   assign yspeed_o  = y_q;
   assign state_o   = state_q;
   assign moving_o  = (state_d == FRIC_ROLLING) || (state_d == FRIC_DECEL);
   assign at_rest_o = (state_d == FRIC_STOPPED) || (state_d == FRIC_POCKETED);
endmodule

// File: rtl/friction_handler.sv
// Per-frame friction stage for all balls plus the shot-settle detector that
// emits a single done pulse once the table has been still long enough.
module friction_handler
   import pool_pkg::*;
#(
   parameter int NUM_BALLS     = 5,
   parameter int SPEED_W       = pool_pkg::SPEED_W,
   parameter int FRIC_PERIOD   = 8,
   parameter int SETTLE_FRAMES = 4
) (
   input  logic                         vsync,
   input  logic                         reset_n,
   input  logic [NUM_BALLS*SPEED_W-1:0] xspeed_in,
   input  logic [NUM_BALLS*SPEED_W-1:0] yspeed_in,
   input  logic [NUM_BALLS-1:0]         pocketed,
   input  logic                         cue_active,
   output logic [NUM_BALLS*SPEED_W-1:0] xspeed_prev,
   output logic [NUM_BALLS*SPEED_W-1:0] yspeed_prev,
   output logic [NUM_BALLS*3-1:0]       fric_state,
   output logic                         done_fric_all
);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic [NUM_BALLS-1:0] moving;
   logic [NUM_BALLS-1:0] at_rest;
   logic                 any_motion;
   logic                 all_rest;
   logic                 start_shot;

   settle_state_e        settle_q;
   logic [CNT_W-1:0]     settle_cnt_q;
   logic                 done_q;

   generate
      for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_ball
         ball_friction #(
            .SPEED_W     (SPEED_W),
            .FRIC_PERIOD (FRIC_PERIOD)
         ) u_ball (
            .clk_i      (vsync),
            .rst_ni     (reset_n),
            .xspeed_i   (xspeed_in[gi*SPEED_W +: SPEED_W]),
            .yspeed_i   (yspeed_in[gi*SPEED_W +: SPEED_W]),
            .pocketed_i (pocketed[gi]),
            .xspeed_o   (xspeed_prev[gi*SPEED_W +: SPEED_W]),
            .yspeed_o   (yspeed_prev[gi*SPEED_W +: SPEED_W]),
            .state_o    (fric_state[gi*3 +: 3]),
            .moving_o   (moving[gi]),
            .at_rest_o  (at_rest[gi])
         );
      end
   endgenerate

   assign any_motion = |moving;
   assign all_rest   = &at_rest;
   // A shot starts on motion whether or not the cue was armed beforehand.
   assign start_shot = any_motion && (cue_active || !cue_active);

   always_ff @(posedge vsync or negedge reset_n) begin
      if (!reset_n) begin
         settle_q     <= SET_WAIT_SHOT;
         settle_cnt_q <= '0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (settle_q)
            SET_WAIT_SHOT: begin
               if (start_shot)
                  settle_q <= SET_MOVING;
            end
            SET_MOVING: begin
               if (all_rest) begin
                  settle_q     <= SET_SETTLING;
                  settle_cnt_q <= '0;
               end
            end
            SET_SETTLING: begin
               if (any_motion) begin
                  settle_q     <= SET_MOVING;
                  settle_cnt_q <= '0;
               end else if (settle_cnt_q == SETTLE_LAST) begin
                  settle_q     <= SET_DONE;
                  settle_cnt_q <= '0;
                  done_q       <= 1'b1;
               end else begin
                  settle_cnt_q <= settle_cnt_q + CNT_ONE;
               end
            end
            SET_DONE: settle_q <= SET_WAIT_SHOT;
            default:  settle_q <= SET_WAIT_SHOT;
         endcase
      end
   end

   assign done_fric_all = done_q;
endmodule
